single_cycle_top: RTL and testbench

// - Top of the single-cycle RV32I-subset processor: PC, instruction ROM, register file, decoder, ALU,

---
 rtl/single_cycle_top.sv | 181 ++++++++++++++++++
 tb/tb_single_cycle_top.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/single_cycle_top.sv
// -----------------------------------------------------------------------------
// single_cycle_top
//   Single-cycle RV32I-subset processor. It contains the PC, instruction ROM,
//   register file, decoder, immediate extender, ALU and data RAM, all clocked by
//   clk. Every instruction completes in one cycle. Supported instructions are
//   lw, sw, add, sub, and, or, slt, addi, andi, ori, slti, beq and jal. Any other
//   encoding executes as a no-op: no register or memory write, and the PC
//   advances by 4.
//
// Parameters
//   IMEM_FILE   name of the instruction image; ROM contents are provided by
//               the surrounding environment
//   IMEM_WORDS  instruction ROM depth in 32-bit words
//   DMEM_WORDS  data RAM depth in 32-bit words (indexed by dataAddress[7:2])
//
// Ports
//   clk          single clock; all state updates on the rising edge
//   reset        asynchronous, active-low (0 = in reset)
//   writeData    store data, i.e. the rs2 value of the current instruction
//   dataAddress  ALU result; the data-memory byte address for lw/sw
//   memWrite     1 while the current instruction is sw (forced 0 in reset)
// -----------------------------------------------------------------------------
module single_cycle_top #(
  parameter string IMEM_FILE  = "riscvtest.txt",
  parameter int    IMEM_WORDS = 64,
  parameter int    DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] writeData,
  output logic [31:0] dataAddress,
  output logic        memWrite
);

  localparam int IMEM_AW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam int DMEM_AW = 6;

  typedef enum logic [2:0] {
    CLS_NOP, CLS_LW, CLS_SW, CLS_RTYPE, CLS_IALU, CLS_BEQ, CLS_JAL
  } instr_cls_e;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  } alu_op_e;

  logic [31:0] imem   [IMEM_WORDS];
  logic [31:0] rf_q   [32];
  logic [31:0] dmem_q [DMEM_WORDS];

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr;
  logic        imem_hit;
  instr_cls_e  cls;
  alu_op_e     alu_op;
  logic [31:0] imm;
  logic [31:0] rs1_val, rs2_val, alu_b, alu_result;
  logic        zero;
  logic [31:0] pc_plus4, pc_target, rd_data, dmem_rdata;
  logic        reg_write, dmem_hit;
  logic [DMEM_AW-1:0] dmem_idx;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rs1, rs2, rd;

  // Fetch. PC[1:0] is ignored, and addresses past the ROM read as 0, which
  // decodes as a no-op.
  assign imem_hit = ({2'b00, pc_q[31:2]} < 32'(IMEM_WORDS));
  assign instr    = imem_hit ? imem[pc_q[IMEM_AW+1:2]] : '0;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  // Decode
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statements can leave a latch behind.
    cls    = CLS_NOP;
    alu_op = ALU_ADD;
    case (opcode)
      7'b0000011: if (funct3 == 3'b010) cls = CLS_LW;
      7'b0100011: if (funct3 == 3'b010) cls = CLS_SW;
      7'b0110011: begin
        cls = CLS_RTYPE;
        case (funct3)
          3'b000:  alu_op = instr[30] ? ALU_SUB : ALU_ADD;
          3'b111:  alu_op = ALU_AND;
          3'b110:  alu_op = ALU_OR;
          3'b010:  alu_op = ALU_SLT;
          default: cls    = CLS_NOP;
        endcase
      end
      7'b0010011: begin
        cls = CLS_IALU;
        case (funct3)
          3'b000:  alu_op = ALU_ADD;
          3'b111:  alu_op = ALU_AND;
          3'b110:  alu_op = ALU_OR;
          3'b010:  alu_op = ALU_SLT;
          default: cls    = CLS_NOP;
        endcase
      end
      7'b1100011: if (funct3 == 3'b000) begin
        cls    = CLS_BEQ;
        alu_op = ALU_SUB;
      end
      7'b1101111: cls = CLS_JAL;
      default: ;
    endcase
  end

  // Immediate extension. Every format sign-extends from instr[31].
  always_comb begin
    case (cls)
      CLS_SW:  imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      CLS_BEQ: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      CLS_JAL: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: imm = {{20{instr[31]}}, instr[31:20]};
    endcase
  end

  // Register file reads. x0 is hard-wired to zero.
  assign rs1_val = (rs1 == 5'd0) ? '0 : rf_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : rf_q[rs2];

  // ALU
  assign alu_b = ((cls == CLS_RTYPE) || (cls == CLS_BEQ)) ? rs2_val : imm;

  always_comb begin
    case (alu_op)
      ALU_SUB: alu_result = rs1_val - alu_b;
      ALU_AND: alu_result = rs1_val & alu_b;
      ALU_OR:  alu_result = rs1_val | alu_b;
      ALU_SLT: alu_result = {31'd0, $signed(rs1_val) < $signed(alu_b)};
      default: alu_result = rs1_val + alu_b;
    endcase
  end

  assign zero = (alu_result == '0);

  // Data RAM read: combinational, word-indexed by address bits [7:2].
  assign dmem_idx   = alu_result[7:2];
  assign dmem_hit   = ({26'd0, dmem_idx} < 32'(DMEM_WORDS));
  assign dmem_rdata = dmem_hit ? dmem_q[dmem_idx] : '0;

  // Next PC and write-back. jal has priority over lw, which has priority
  // over the ALU result.
  assign pc_plus4  = pc_q + 32'd4;
  assign pc_target = pc_q + imm;
  assign pc_d      = ((cls == CLS_JAL) || ((cls == CLS_BEQ) && zero)) ? pc_target
                                                                       : pc_plus4;
  assign rd_data   = (cls == CLS_JAL) ? pc_plus4 :
                     (cls == CLS_LW)  ? dmem_rdata : alu_result;
  assign reg_write = (cls == CLS_LW) || (cls == CLS_RTYPE) ||
                     (cls == CLS_IALU) || (cls == CLS_JAL);

  // Exported memory bus. Stores are suppressed while the core is held in reset.
  assign dataAddress = alu_result;
  assign writeData   = rs2_val;
  assign memWrite    = (cls == CLS_SW) && reset;

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples values from before the edge.
    if (!reset) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  // NOTE: the register file and data RAM have no reset. Their contents
  // survive a reset, and reset only blocks writes while it is asserted.
  always_ff @(posedge clk) begin
    if (reset && reg_write && (rd != 5'd0)) rf_q[rd] <= rd_data;
    if (memWrite && dmem_hit) dmem_q[dmem_idx] <= rs2_val;
  end

endmodule

// File: tb/tb_single_cycle_top.sv
module tb_single_cycle_top;

  logic        clk;
  logic        reset;
  logic [31:0] writeData;
  logic [31:0] dataAddress;
  logic        memWrite;

  single_cycle_top #(
    .IMEM_FILE  (""),
    .IMEM_WORDS (64),
    .DMEM_WORDS (64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .writeData   (writeData),
    .dataAddress (dataAddress),
    .memWrite    (memWrite)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } store_t;

  store_t      exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  string       cur_test = "init";
  logic [31:0] prog [64];

  // Standard riscvtest.txt image
  logic [31:0] rv_image [21] = '{
    32'h00500113, 32'h00C00193, 32'hFF718393, 32'h0023E233, 32'h0041F2B3,
    32'h004282B3, 32'h02728863, 32'h0041A233, 32'h00020463, 32'h00000293,
    32'h0023A233, 32'h005203B3, 32'h402383B3, 32'h0471AA23, 32'h06002103,
    32'h005104B3, 32'h008001EF, 32'h00100113, 32'h00910133, 32'h0221A023,
    32'h00210063
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", cur_test, name, act, exp);
    end
  endtask

  // Instruction encoders
  function automatic logic [31:0] f_i(input int f3, input int rd, input int rs1, input int imm);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0010011};
  endfunction
  function automatic logic [31:0] f_addi(input int rd, input int rs1, input int imm);
    return f_i(0, rd, rs1, imm);
  endfunction
  function automatic logic [31:0] f_r(input int f7, input int f3, input int rd, input int rs1, input int rs2);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
  endfunction
  function automatic logic [31:0] f_sw(input int rs2, input int rs1, input int imm);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] f_lw(input int rd, input int rs1, input int imm);
    return {imm[11:0], rs1[4:0], 3'b010, rd[4:0], 7'b0000011};
  endfunction
  function automatic logic [31:0] f_beq(input int rs1, input int rs2, input int imm);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] f_jal(input int rd, input int imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction

  task automatic push(input logic [31:0] addr, input logic [31:0] data);
    store_t s;
    s.addr = addr;
    s.data = data;
    exp_q.push_back(s);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = 32'h0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 64; i++) dut.imem[i] = prog[i];
  endtask

  // Release reset, run a fixed number of cycles, re-assert reset and confirm
  // that every expected store was seen.
  task automatic run_prog(input int cycles);
    @(posedge clk); #2;
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #2;
    reset = 1'b0;
    check("pending_stores", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Monitor: every store presented on the bus is compared with the next
  // expected one.
  always @(negedge clk) begin
    store_t e;
    if (reset === 1'b1 && memWrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s.unexpected_store: got addr 0x%08h data 0x%08h, expected no store",
                 cur_test, dataAddress, writeData);
      end else begin
        e = exp_q.pop_front();
        check("store_addr", dataAddress, e.addr);
        check("store_data", writeData, e.data);
      end
    end
  end

  localparam logic [31:0] LOOP = 32'h00000063;   // beq x0,x0,0

  initial begin
    clk   = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;

    // Reset hold: instruction 0 is a store, but it must not be issued.
    cur_test = "reset_hold";
    clear_prog();
    prog[0] = f_sw(0, 0, 8);
    prog[1] = LOOP;
    load_prog();
    repeat (2) begin
      @(negedge clk);
      check("pc", dut.pc_q, 32'h0);
      check("memWrite", {31'd0, memWrite}, 32'h0);
      check("dataAddress", dataAddress, 32'd8);
    end
    push(32'd8, 32'd0);
    run_prog(5);

    // Standard image
    cur_test = "riscvtest";
    clear_prog();
    for (int i = 0; i < 21; i++) prog[i] = rv_image[i];
    load_prog();
    push(32'd96, 32'd7);
    push(32'd100, 32'd25);
    run_prog(40);

    // I-type ALU and signed compares
    cur_test = "ialu";
    clear_prog();
    prog[0]  = f_addi(1, 0, -5);
    prog[1]  = f_i(2, 2, 1, 0);              // slti x2,x1,0
    prog[2]  = f_sw(1, 0, 0);
    prog[3]  = f_sw(2, 0, 4);
    prog[4]  = f_i(7, 3, 1, 'h0F);           // andi x3,x1,0xF
    prog[5]  = f_sw(3, 0, 8);
    prog[6]  = f_i(2, 4, 1, -6);             // slti x4,x1,-6
    prog[7]  = f_sw(4, 0, 12);
    prog[8]  = f_i(6, 5, 0, 'h7FF);          // ori x5,x0,0x7FF
    prog[9]  = f_sw(5, 0, 16);
    prog[10] = f_r(0, 2, 6, 1, 5);           // slt x6,x1,x5
    prog[11] = f_sw(6, 0, 20);
    prog[12] = f_r('h20, 0, 7, 0, 5);        // sub x7,x0,x5
    prog[13] = f_sw(7, 0, 24);
    prog[14] = LOOP;
    load_prog();
    push(32'd0,  32'hFFFFFFFB);
    push(32'd4,  32'd1);
    push(32'd8,  32'h0000000B);
    push(32'd12, 32'd0);
    push(32'd16, 32'h000007FF);
    push(32'd20, 32'd1);
    push(32'd24, 32'hFFFFF801);
    run_prog(25);

    // beq taken, beq not taken, and a skipped store
    cur_test = "beq";
    clear_prog();
    prog[0] = f_addi(1, 0, 3);
    prog[1] = f_beq(1, 1, 8);
    prog[2] = f_addi(1, 0, 9);
    prog[3] = f_sw(1, 0, 16);
    prog[4] = f_beq(1, 0, 8);
    prog[5] = f_sw(1, 0, 20);
    prog[6] = f_beq(0, 0, 8);
    prog[7] = f_sw(1, 0, 28);
    prog[8] = LOOP;
    load_prog();
    push(32'd16, 32'd3);
    push(32'd20, 32'd3);
    run_prog(15);

    // jal x5,+12 at PC 0x10
    cur_test = "jal";
    clear_prog();
    for (int i = 0; i < 4; i++) prog[i] = f_addi(0, 0, 0);
    prog[4] = f_jal(5, 12);
    prog[5] = f_addi(5, 0, 1);
    prog[6] = f_sw(5, 0, 0);
    prog[7] = f_sw(5, 0, 24);
    prog[8] = LOOP;
    load_prog();
    push(32'd24, 32'h00000014);
    run_prog(15);

    // sw then lw round trip of 0xA5A5A5A5, and writes to x0 ignored
    cur_test = "sw_lw";
    clear_prog();
    prog[0] = f_addi(1, 0, 'hA5);
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 8; j++) prog[1 + k*9 + j] = f_r(0, 0, 1, 1, 1);  // x1 <<= 1
      prog[9 + k*9] = f_addi(1, 1, 'hA5);
    end
    prog[28] = f_sw(1, 0, 4);
    prog[29] = f_lw(2, 0, 4);
    prog[30] = f_sw(2, 0, 8);
    prog[31] = f_addi(0, 0, 5);
    prog[32] = f_sw(0, 0, 12);
    prog[33] = LOOP;
    load_prog();
    push(32'd4,  32'hA5A5A5A5);
    push(32'd8,  32'hA5A5A5A5);
    push(32'd12, 32'd0);
    run_prog(45);

    // Reset asserted mid-program, then the program re-executes from PC 0
    cur_test = "reset_mid";
    clear_prog();
    prog[0] = f_addi(7, 0, 'h11);
    prog[1] = f_sw(7, 0, 40);
    prog[2] = f_addi(7, 7, 1);
    prog[3] = f_sw(7, 0, 44);
    prog[4] = LOOP;
    load_prog();
    push(32'd40, 32'h11);
    @(posedge clk); #2;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("pc_async_clear", dut.pc_q, 32'h0);
    check("memWrite_in_reset", {31'd0, memWrite}, 32'h0);
    check("pending_first_run", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    push(32'd40, 32'h11);
    push(32'd44, 32'h12);
    run_prog(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
